mem_port_scheduler: RTL and testbench

MEM_PORT_SCHEDULER -- requirements
Module: mem_port_scheduler

---
 rtl/mem_port_scheduler.sv | 122 ++++++++++++
 tb/tb_mem_port_scheduler.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_scheduler.sv
// rtl/mem_port_scheduler.sv - single-port memory arbiter between instruction fetch and data access
module mem_port_scheduler #(
  parameter int AW   = 32,
  parameter int DW   = 32,
  parameter int LAT  = 2,
  parameter int FAIR = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_valid,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_valid,
  input  logic          flush,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          stall_f,
  output logic          stall_m
);

  localparam int FW = (FAIR < 1) ? 1 : $clog2(FAIR + 1);
  localparam logic [3:0]    CNT_INIT = 4'(LAT - 1);
  localparam logic [FW-1:0] FAIR_V   = FW'(FAIR);

  typedef enum logic {IDLE, WAIT} state_t;
  typedef enum logic {OWN_IF, OWN_DM} owner_t;

  state_t        state;
  owner_t        owner;
  logic [3:0]    cnt;
  logic [FW-1:0] fcnt;
  logic          discard;

  logic done;
  logic can_issue;
  logic issue_dm;
  logic issue_if;

  // Issue decision: data wins unless a fetch has been starved for FAIR grants;
  // the completion cycle doubles as an issue slot so the port never idles.
  always_comb begin
    done      = (state == WAIT) && (cnt == 4'd0);
    can_issue = rst && ((state == IDLE) || done);
    issue_dm  = can_issue && dm_req && (!if_req || (fcnt < FAIR_V));
    issue_if  = can_issue && !issue_dm && if_req && !flush;
  end

  // Memory command and completion signalling; the response only exists during
  // the completion cycle, so valids and read data are decoded from state.
  always_comb begin
    mem_en    = issue_dm || issue_if;
    mem_we    = issue_dm && dm_we;
    mem_addr  = '0;
    mem_wdata = '0;
    if (issue_dm) begin
      mem_addr  = dm_addr;
      mem_wdata = dm_wdata;
    end else if (issue_if) begin
      mem_addr  = if_addr;
    end
    if_valid = rst && done && (owner == OWN_IF) && !discard;
    dm_valid = rst && done && (owner == OWN_DM);
    if_rdata = if_valid ? mem_rdata : '0;
    dm_rdata = dm_valid ? mem_rdata : '0;
    stall_f  = if_req && !if_valid && !flush;
    stall_m  = dm_req && !dm_valid;
  end

  // Scheduler FSM with owner, latency counter, discard flag and fairness counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      owner   <= OWN_IF;
      cnt     <= 4'd0;
      fcnt    <= '0;
      discard <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (issue_dm || issue_if) begin
            state <= WAIT;
            cnt   <= CNT_INIT;
          end
        end
        WAIT: begin
          if (flush && (owner == OWN_IF)) begin
            discard <= 1'b1;
          end
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else if (issue_dm || issue_if) begin
            cnt <= CNT_INIT;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      if (issue_dm || issue_if) begin
        owner   <= issue_dm ? OWN_DM : OWN_IF;
        discard <= 1'b0;
      end

      if (issue_if || !if_req) begin
        fcnt <= '0;
      end else if (issue_dm && (fcnt != FAIR_V)) begin
        fcnt <= fcnt + FW'(1);
      end
    end
  end

endmodule

// File: tb/tb_mem_port_scheduler.sv
// tb/tb_mem_port_scheduler.sv - self-checking bench for mem_port_scheduler
module tb_mem_port_scheduler;
  localparam int AW = 32, DW = 32, LAT = 2, FAIR = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic [DW-1:0] if_rdata;
  logic          if_valid;
  logic          dm_req = 1'b0;
  logic          dm_we = 1'b0;
  logic [AW-1:0] dm_addr = '0;
  logic [DW-1:0] dm_wdata = '0;
  logic [DW-1:0] dm_rdata;
  logic          dm_valid;
  logic          flush = 1'b0;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          stall_f, stall_m;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;

  logic [DW-1:0] resp_dat [16];
  bit            resp_vld [16];
  logic [DW-1:0] mem     [logic [AW-1:0]];
  logic [DW-1:0] ref_mem [logic [AW-1:0]];

  mem_port_scheduler #(.AW(AW), .DW(DW), .LAT(LAT), .FAIR(FAIR)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_valid(dm_valid), .flush(flush),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall_f(stall_f), .stall_m(stall_m)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] hash(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  function automatic logic [31:0] raddr();
    logic [3:0] w;
    w = 4'($urandom_range(0, 15));
    return {26'd0, w, 2'b00};
  endfunction

  function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
    return mem.exists(a) ? mem[a] : hash(a);
  endfunction

  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : hash(a);
  endfunction

  // Advance one clock and present the memory response scheduled for this cycle.
  task automatic tick();
    int idx;
    @(posedge clk);
    cyc++;
    #1;
    idx = cyc % 16;
    if (resp_vld[idx]) begin
      mem_rdata     = resp_dat[idx];
      resp_vld[idx] = 1'b0;
    end else begin
      mem_rdata = $urandom;
    end
  endtask

  // Let inputs settle, then let the memory model accept any command.
  task automatic settle();
    int idx;
    #1;
    if (mem_en) begin
      idx = (cyc + LAT) % 16;
      if (mem_we) begin
        mem[mem_addr] = mem_wdata;
        resp_dat[idx] = $urandom;
      end else begin
        resp_dat[idx] = mem_rd(mem_addr);
      end
      resp_vld[idx] = 1'b1;
    end
  endtask

  task automatic idle(input int n);
    if_req = 0; dm_req = 0; dm_we = 0; flush = 0;
    for (int i = 0; i < n; i++) begin
      tick(); settle();
    end
  endtask

  task automatic test_reset();
    rst = 0; if_req = 1; dm_req = 1;
    tick(); settle();
    tick(); settle();
    vectors++; if (mem_en !== 1'b0) begin errors++; $display("FAIL reset_mem_en: got %b expected 0", mem_en); end
    vectors++; if (if_valid !== 1'b0) begin errors++; $display("FAIL reset_if_valid: got %b expected 0", if_valid); end
    vectors++; if (dm_valid !== 1'b0) begin errors++; $display("FAIL reset_dm_valid: got %b expected 0", dm_valid); end
    vectors++; if (if_rdata !== '0) begin errors++; $display("FAIL reset_if_rdata: got %h expected 0", if_rdata); end
    vectors++; if (dm_rdata !== '0) begin errors++; $display("FAIL reset_dm_rdata: got %h expected 0", dm_rdata); end
    if_req = 0; dm_req = 0;
    tick(); settle();
    vectors++; if ({stall_f, stall_m} !== 2'b00) begin errors++; $display("FAIL reset_stall: got %b expected 00", {stall_f, stall_m}); end
    rst = 1;
    idle(2);
  endtask

  task automatic test_fetch();
    tick(); if_req = 1; if_addr = 32'h10; settle();
    vectors++; if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 32'h10}) begin errors++; $display("FAIL fetch_issue: got en=%b we=%b addr=%h expected 1 0 00000010", mem_en, mem_we, mem_addr); end
    vectors++; if (stall_f !== 1'b1) begin errors++; $display("FAIL fetch_stall_t: got %b expected 1", stall_f); end
    for (int i = 1; i < LAT; i++) begin
      tick(); settle();
      vectors++; if ({mem_en, stall_f, if_valid} !== 3'b010) begin errors++; $display("FAIL fetch_wait: got en/stall/valid=%b expected 010", {mem_en, stall_f, if_valid}); end
    end
    tick(); if_req = 0; settle();
    vectors++; if (if_valid !== 1'b1) begin errors++; $display("FAIL fetch_valid: got %b expected 1", if_valid); end
    vectors++; if (if_rdata !== 32'hA5A5A5A5) begin errors++; $display("FAIL fetch_rdata: got %h expected a5a5a5a5", if_rdata); end
    idle(2);
  endtask

  task automatic test_contention();
    tick(); if_req = 1; if_addr = 32'h20; dm_req = 1; dm_we = 0; dm_addr = 32'h200; settle();
    vectors++; if ({mem_en, mem_addr} !== {1'b1, 32'h200}) begin errors++; $display("FAIL cont_dm_first: got en=%b addr=%h expected 1 00000200", mem_en, mem_addr); end
    for (int i = 1; i < LAT; i++) begin tick(); settle(); end
    tick(); dm_req = 0; settle();
    vectors++; if ({dm_valid, if_valid} !== 2'b10) begin errors++; $display("FAIL cont_dm_valid: got dm/if=%b expected 10", {dm_valid, if_valid}); end
    vectors++; if (dm_rdata !== hash(32'h200)) begin errors++; $display("FAIL cont_dm_rdata: got %h expected %h", dm_rdata, hash(32'h200)); end
    vectors++; if ({mem_en, mem_addr} !== {1'b1, 32'h20}) begin errors++; $display("FAIL cont_if_b2b: got en=%b addr=%h expected 1 00000020", mem_en, mem_addr); end
    for (int i = 1; i < LAT; i++) begin tick(); settle(); end
    tick(); if_req = 0; settle();
    vectors++; if ({if_valid, dm_valid} !== 2'b10) begin errors++; $display("FAIL cont_if_valid: got if/dm=%b expected 10", {if_valid, dm_valid}); end
    vectors++; if (if_rdata !== hash(32'h20)) begin errors++; $display("FAIL cont_if_rdata: got %h expected %h", if_rdata, hash(32'h20)); end
    idle(2);
  endtask

  task automatic test_fairness();
    bit seq[$];
    bit exp_seq[6] = '{1, 1, 1, 1, 0, 1};
    tick(); if_req = 1; if_addr = 32'h30; dm_req = 1; dm_we = 0; dm_addr = 32'h300; settle();
    if (mem_en) seq.push_back(mem_addr == 32'h300);
    for (int i = 0; i < 40 && seq.size() < 6; i++) begin
      tick();
      if (if_valid) if_req = 0;
      settle();
      if (mem_en) seq.push_back(mem_addr == 32'h300);
    end
    vectors++; if (seq.size() !== 6) begin errors++; $display("FAIL fair_count: got %0d issues expected 6", seq.size()); end
    for (int i = 0; i < 6 && i < seq.size(); i++) begin
      vectors++; if (seq[i] !== exp_seq[i]) begin errors++; $display("FAIL fair_order[%0d]: got dm=%b expected dm=%b", i, seq[i], exp_seq[i]); end
    end
    idle(LAT + 2);
  endtask

  task automatic test_flush();
    tick(); if_req = 1; if_addr = 32'h50; settle();
    vectors++; if ({mem_en, mem_addr} !== {1'b1, 32'h50}) begin errors++; $display("FAIL flush_issue: got en=%b addr=%h expected 1 00000050", mem_en, mem_addr); end
    tick(); flush = 1; if_addr = 32'h54; settle();
    vectors++; if ({stall_f, mem_en} !== 2'b00) begin errors++; $display("FAIL flush_stall: got stall/en=%b expected 00", {stall_f, mem_en}); end
    for (int i = 2; i < LAT; i++) begin tick(); flush = 0; settle(); end
    tick(); flush = 0; settle();
    vectors++; if (if_valid !== 1'b0) begin errors++; $display("FAIL flush_discard: got if_valid=%b expected 0", if_valid); end
    vectors++; if ({mem_en, mem_addr} !== {1'b1, 32'h54}) begin errors++; $display("FAIL flush_reissue: got en=%b addr=%h expected 1 00000054", mem_en, mem_addr); end
    for (int i = 1; i < LAT; i++) begin tick(); settle(); end
    tick(); if_req = 0; settle();
    vectors++; if ({if_valid, if_rdata} !== {1'b1, hash(32'h54)}) begin errors++; $display("FAIL flush_next: got valid=%b data=%h expected 1 %h", if_valid, if_rdata, hash(32'h54)); end
    idle(2);
  endtask

  task automatic test_store();
    tick(); dm_req = 1; dm_we = 1; dm_addr = 32'h40; dm_wdata = 32'h12345678; settle();
    vectors++; if ({mem_en, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 32'h40, 32'h12345678}) begin errors++; $display("FAIL store_issue: got en=%b we=%b addr=%h wdata=%h expected 1 1 00000040 12345678", mem_en, mem_we, mem_addr, mem_wdata); end
    for (int i = 1; i < LAT; i++) begin
      tick(); settle();
      vectors++; if ({mem_en, mem_we, dm_valid} !== 3'b000) begin errors++; $display("FAIL store_wait: got en/we/valid=%b expected 000", {mem_en, mem_we, dm_valid}); end
    end
    tick(); dm_req = 0; dm_we = 0; settle();
    vectors++; if (dm_valid !== 1'b1) begin errors++; $display("FAIL store_valid: got %b expected 1", dm_valid); end
    idle(2);
  endtask

  task automatic test_reset_midwait();
    tick(); dm_req = 1; dm_we = 0; dm_addr = 32'h80; settle();
    vectors++; if (mem_en !== 1'b1) begin errors++; $display("FAIL rstw_issue: got %b expected 1", mem_en); end
    tick(); rst = 0; settle();
    vectors++; if (mem_en !== 1'b0) begin errors++; $display("FAIL rstw_mem_en: got %b expected 0", mem_en); end
    tick(); rst = 1; settle();
    vectors++; if ({dm_valid, if_valid, dm_rdata} !== {2'b00, 32'h0}) begin errors++; $display("FAIL rstw_no_valid: got dm=%b if=%b data=%h expected 0 0 0", dm_valid, if_valid, dm_rdata); end
    vectors++; if ({mem_en, mem_addr} !== {1'b1, 32'h80}) begin errors++; $display("FAIL rstw_reissue: got en=%b addr=%h expected 1 00000080", mem_en, mem_addr); end
    for (int i = 1; i < LAT; i++) begin tick(); settle(); end
    tick(); dm_req = 0; settle();
    vectors++; if ({dm_valid, dm_rdata} !== {1'b1, hash(32'h80)}) begin errors++; $display("FAIL rstw_complete: got valid=%b data=%h expected 1 %h", dm_valid, dm_rdata, hash(32'h80)); end
    idle(2);
  endtask

  // Random traffic against a transaction-level model: one command at a time,
  // each completing LAT cycles after issue, with fetch starvation bounded by FAIR.
  task automatic test_random();
    bit m_busy = 0, m_own_if = 0, m_disc = 0, m_we = 0;
    int m_done = 0, m_fcnt = 0;
    logic [DW-1:0] m_exp = '0;
    bit r_rst, completing, e_ifv, e_dmv, can, iss_dm, iss_if;
    ref_mem = mem;
    for (int n = 0; n < 3000; n++) begin
      tick();
      r_rst = ($urandom_range(0, 199) != 0);
      rst = r_rst;
      completing = m_busy && (cyc == m_done);
      e_ifv = r_rst && completing && m_own_if && !m_disc;
      e_dmv = r_rst && completing && !m_own_if;
      if (e_ifv) begin if_req = 1'($urandom_range(0, 1)); if_addr = raddr(); end
      else if (!if_req && $urandom_range(0, 2) == 0) begin if_req = 1; if_addr = raddr(); end
      if (e_dmv || (!dm_req && $urandom_range(0, 2) == 0)) begin
        dm_req = e_dmv ? 1'($urandom_range(0, 1)) : 1'b1;
        dm_we = 1'($urandom_range(0, 1)); dm_addr = raddr(); dm_wdata = $urandom;
      end
      flush = ($urandom_range(0, 7) == 0);
      if (flush) begin if_req = 1'($urandom_range(0, 1)); if_addr = raddr(); end
      can    = r_rst && (!m_busy || completing);
      iss_dm = can && dm_req && (!if_req || m_fcnt < FAIR);
      iss_if = can && !iss_dm && if_req && !flush;
      settle();
      vectors++; if (mem_en !== (iss_dm || iss_if)) begin errors++; $display("FAIL rnd_mem_en cyc %0d: got %b expected %b", cyc, mem_en, iss_dm || iss_if); end
      if (iss_dm || iss_if) begin
        vectors++;
        if ({mem_addr, mem_we, mem_wdata} !== (iss_dm ? {dm_addr, dm_we, dm_wdata} : {if_addr, 1'b0, 32'h0})) begin
          errors++; $display("FAIL rnd_cmd cyc %0d: got addr=%h we=%b wdata=%h dm_owner=%b", cyc, mem_addr, mem_we, mem_wdata, iss_dm);
        end
      end
      vectors++; if ({if_valid, dm_valid} !== {e_ifv, e_dmv}) begin errors++; $display("FAIL rnd_valid cyc %0d: got if/dm=%b%b expected %b%b", cyc, if_valid, dm_valid, e_ifv, e_dmv); end
      if (e_ifv) begin
        vectors++; if (if_rdata !== m_exp) begin errors++; $display("FAIL rnd_if_rdata cyc %0d: got %h expected %h", cyc, if_rdata, m_exp); end
      end
      if (e_dmv && !m_we) begin
        vectors++; if (dm_rdata !== m_exp) begin errors++; $display("FAIL rnd_dm_rdata cyc %0d: got %h expected %h", cyc, dm_rdata, m_exp); end
      end
      vectors++;
      if ({stall_f, stall_m} !== {if_req && !e_ifv && !flush, dm_req && !e_dmv}) begin
        errors++; $display("FAIL rnd_stall cyc %0d: got f/m=%b%b expected %b%b", cyc, stall_f, stall_m, if_req && !e_ifv && !flush, dm_req && !e_dmv);
      end
      if (!r_rst) begin
        m_busy = 0; m_fcnt = 0; m_disc = 0;
      end else begin
        if (flush && m_busy && m_own_if && !completing) m_disc = 1;
        if (completing) m_busy = 0;
        if (iss_dm || iss_if) begin
          m_busy = 1; m_done = cyc + LAT; m_own_if = iss_if; m_disc = 0;
          m_we = iss_dm && dm_we;
          if (m_we) ref_mem[dm_addr] = dm_wdata;
          m_exp = iss_dm ? ref_rd(dm_addr) : ref_rd(if_addr);
        end
        if (iss_if || !if_req) m_fcnt = 0;
        else if (iss_dm && m_fcnt < FAIR) m_fcnt++;
      end
    end
    rst = 1;
    idle(LAT + 2);
  endtask

  initial begin
    mem[32'h10] = 32'hA5A5A5A5;
    test_reset();
    test_fetch();
    test_contention();
    test_fairness();
    test_flush();
    test_store();
    test_reset_midwait();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
